// File: rtl/prog_loader_if.sv
// Bus bundle between the serial program loader and its environment:
// serial input in, RAM write port and status out.
interface prog_loader_if;
  logic       rx;
  logic       wr_enable;
  logic [7:0] addr_bus;
  logic [7:0] wdata;
  logic       cpu_run;
  logic       err;
  logic [7:0] byte_count;

  modport master (
    input  rx,
    output wr_enable, addr_bus, wdata, cpu_run, err, byte_count
  );

  modport slave (
    output rx,
    input  wr_enable, addr_bus, wdata, cpu_run, err, byte_count
  );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: 8N1 receiver feeding a length/data/checksum frame
// parser that writes RAM and releases the CPU once the checksum matches.
module prog_loader #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    WAIT_LEN,
    WAIT_DATA,
    WAIT_SUM,
    RUNNING
  } load_state_t;

  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_prev;

  rx_state_t   r_rx_state;
  rx_state_t   w_rx_next;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_byte_valid;
  logic        r_frame_err;
  logic        w_rx_done;
  logic        w_rx_ferr;
  logic        w_start_edge;
  logic        w_half_hit;
  logic        w_full_hit;

  load_state_t r_ld_state;
  load_state_t w_ld_next;
  logic        r_wr_enable;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_err;
  logic [7:0]  r_count;
  logic [7:0]  r_sum;
  logic [8:0]  r_len;
  logic        w_latch_len;
  logic        w_do_write;
  logic        w_set_err;
  logic        w_last;

  // Flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_start_edge = r_rx_prev & ~r_rx_sync;
  assign w_half_hit   = (r_clk_cnt == HALF_BIT);
  assign w_full_hit   = (r_clk_cnt == FULL_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_done = 1'b0;
    w_rx_ferr = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_start_edge) w_rx_next = RX_START;
      end
      RX_START: begin
        if (w_half_hit) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (w_full_hit && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
      end
      RX_STOP: begin
        if (w_full_hit) begin
          if (r_rx_sync) begin
            w_rx_done = 1'b1;
            w_rx_next = RX_IDLE;
          end else begin
            w_rx_ferr = 1'b1;
            w_rx_next = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (r_rx_sync) w_rx_next = RX_IDLE;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // Counter reads k exactly k cycles after the start edge or the last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt    <= 16'd1;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_rx_done;
      r_frame_err  <= w_rx_ferr;
      case (r_rx_state)
        RX_START: begin
          if (w_half_hit) begin
            r_clk_cnt <= 16'd1;
            r_bit_idx <= 3'd0;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (w_full_hit) begin
            r_clk_cnt <= 16'd1;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_full_hit) r_clk_cnt <= 16'd1;
          else            r_clk_cnt <= r_clk_cnt + 16'd1;
        end
        default: r_clk_cnt <= 16'd1;
      endcase
    end
  end

  assign w_last = ({1'b0, r_count} == (r_len - 9'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_state <= WAIT_LEN;
    end else begin
      r_ld_state <= w_ld_next;
    end
  end

  always_comb begin
    w_ld_next   = r_ld_state;
    w_latch_len = 1'b0;
    w_do_write  = 1'b0;
    w_set_err   = 1'b0;
    case (r_ld_state)
      WAIT_LEN: begin
        if (r_byte_valid) begin
          w_latch_len = 1'b1;
          w_ld_next   = WAIT_DATA;
        end else if (r_frame_err) begin
          w_set_err = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (r_frame_err) begin
          w_set_err = 1'b1;
          w_ld_next = WAIT_LEN;
        end else if (r_byte_valid) begin
          w_do_write = 1'b1;
          if (w_last) w_ld_next = WAIT_SUM;
        end
      end
      WAIT_SUM: begin
        if (r_frame_err) begin
          w_set_err = 1'b1;
          w_ld_next = WAIT_LEN;
        end else if (r_byte_valid) begin
          if (r_shift == r_sum) begin
            w_ld_next = RUNNING;
          end else begin
            w_set_err = 1'b1;
            w_ld_next = WAIT_LEN;
          end
        end
      end
      RUNNING: w_ld_next = RUNNING;
      default: w_ld_next = WAIT_LEN;
    endcase
  end

  // A length byte of zero encodes a 256-byte payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_enable <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_err       <= 1'b0;
      r_count     <= 8'h00;
      r_sum       <= 8'h00;
      r_len       <= 9'd0;
    end else begin
      r_wr_enable <= w_do_write;
      if (w_latch_len) begin
        r_len   <= (r_shift == 8'h00) ? 9'd256 : {1'b0, r_shift};
        r_sum   <= 8'h00;
        r_count <= 8'h00;
        r_err   <= 1'b0;
      end
      if (w_do_write) begin
        r_addr  <= r_count;
        r_wdata <= r_shift;
        r_sum   <= r_sum + r_shift;
        r_count <= r_count + 8'd1;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

  assign bus.wr_enable  = r_wr_enable;
  assign bus.addr_bus   = r_addr;
  assign bus.wdata      = r_wdata;
  assign bus.cpu_run    = (r_ld_state == RUNNING);
  assign bus.err        = r_err;
  assign bus.byte_count = r_count;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader at CLKS_PER_BIT=4: expected RAM writes are
// queued as frames are sent and popped by an independent write monitor.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_loader_if bus ();

  prog_loader #(
    .CLKS_PER_BIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] expWr[$];
  logic prevWr = 1'b0;

  // Write monitor: every strobe must match the oldest queued {addr, data}.
  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.wr_enable === 1'b1) begin
      checks++;
      if (expWr.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%02h data=%02h, required no write",
                 bus.addr_bus, bus.wdata);
      end else begin
        e = expWr.pop_front();
        if ({bus.addr_bus, bus.wdata} !== e) begin
          errors++;
          $display("[TB] FAIL write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                   bus.addr_bus, bus.wdata, e[15:8], e[7:0]);
        end
      end
      if (prevWr === 1'b1) begin
        checks++;
        errors++;
        $display("[TB] FAIL strobe_width: got wr_enable high 2 cycles, required 1");
      end
    end
    prevWr = bus.wr_enable;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    bus.rx = 1'b0;
    waitCycles(4);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      waitCycles(4);
    end
    bus.rx = stopBit;
    waitCycles(4);
    bus.rx = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    sendByte(b, 1'b1);
  endtask

  task automatic expectWrite(input logic [7:0] a, input logic [7:0] d);
    expWr.push_back({a, d});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic checkStatus(input string tag, input logic runReq,
                             input logic errReq, input logic [7:0] countReq);
    checkOutput({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'(runReq));
    checkOutput({tag, "_err"}, 32'(bus.err), 32'(errReq));
    checkOutput({tag, "_byte_count"}, 32'(bus.byte_count), 32'(countReq));
    checkOutput({tag, "_drained"}, 32'(expWr.size()), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.rx = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(4);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_enable"}, 32'(bus.wr_enable), 32'd0);
    checkOutput({tag, "_addr_bus"}, 32'(bus.addr_bus), 32'h00);
    checkOutput({tag, "_wdata"}, 32'(bus.wdata), 32'h00);
    checkOutput({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    checkOutput({tag, "_byte_count"}, 32'(bus.byte_count), 32'h00);
  endtask

  initial begin
    bus.rx = 1'b1;
    rst = 1'b1;
    waitCycles(3);
    checkResetOutputs("reset");
    rst = 1'b0;
    waitCycles(4);

    // Good 3-byte frame with a one-cycle rx glitch between data bytes.
    applyStimulus(8'h03);
    expectWrite(8'h00, 8'h11); applyStimulus(8'h11);
    waitCycles(6);
    bus.rx = 1'b0;
    waitCycles(1);
    bus.rx = 1'b1;
    waitCycles(10);
    checkOutput("glitch_count", 32'(bus.byte_count), 32'h01);
    expectWrite(8'h01, 8'h22); applyStimulus(8'h22);
    expectWrite(8'h02, 8'h33); applyStimulus(8'h33);
    applyStimulus(8'h66);
    waitCycles(8);
    checkStatus("frame1", 1'b1, 1'b0, 8'h03);

    // Running ignores further frames.
    applyStimulus(8'h01); applyStimulus(8'h55); applyStimulus(8'h55);
    waitCycles(8);
    checkStatus("running", 1'b1, 1'b0, 8'h03);
    doReset();

    // Bad checksum, then recovery frame clears err on its length byte.
    applyStimulus(8'h02);
    expectWrite(8'h00, 8'hAA); applyStimulus(8'hAA);
    expectWrite(8'h01, 8'h55); applyStimulus(8'h55);
    applyStimulus(8'h00);
    waitCycles(8);
    checkStatus("badsum", 1'b0, 1'b1, 8'h02);
    applyStimulus(8'h01);
    waitCycles(4);
    checkOutput("len_clears_err", 32'(bus.err), 32'd0);
    expectWrite(8'h00, 8'h07); applyStimulus(8'h07);
    applyStimulus(8'h07);
    waitCycles(8);
    checkStatus("recover", 1'b1, 1'b0, 8'h01);
    doReset();

    // Framing error on a data byte drops it and returns to WAIT_LEN.
    applyStimulus(8'h02);
    expectWrite(8'h00, 8'h11); applyStimulus(8'h11);
    sendByte(8'h22, 1'b0);
    waitCycles(8);
    checkStatus("frame_err", 1'b0, 1'b1, 8'h01);
    applyStimulus(8'h01);
    expectWrite(8'h00, 8'h07); applyStimulus(8'h07);
    applyStimulus(8'h07);
    waitCycles(8);
    checkStatus("after_ferr", 1'b1, 1'b0, 8'h01);
    doReset();

    // Long break: one framing error, no restart until rx idles high.
    bus.rx = 1'b0;
    waitCycles(100);
    checkStatus("break", 1'b0, 1'b1, 8'h00);
    bus.rx = 1'b1;
    waitCycles(10);
    applyStimulus(8'h01);
    expectWrite(8'h00, 8'h07); applyStimulus(8'h07);
    applyStimulus(8'h07);
    waitCycles(8);
    checkStatus("after_break", 1'b1, 1'b0, 8'h01);
    doReset();

    // Reset mid-byte after two of three data bytes.
    applyStimulus(8'h03);
    expectWrite(8'h00, 8'h10); applyStimulus(8'h10);
    expectWrite(8'h01, 8'h20); applyStimulus(8'h20);
    bus.rx = 1'b0;
    waitCycles(12);
    checkOutput("pre_rst_count", 32'(bus.byte_count), 32'h02);
    rst = 1'b1;
    bus.rx = 1'b1;
    waitCycles(1);
    checkResetOutputs("midrst");
    rst = 1'b0;
    waitCycles(10);
    applyStimulus(8'h02);
    expectWrite(8'h00, 8'h10); applyStimulus(8'h10);
    expectWrite(8'h01, 8'h20); applyStimulus(8'h20);
    applyStimulus(8'h30);
    waitCycles(8);
    checkStatus("fresh", 1'b1, 1'b0, 8'h02);
    doReset();

    // Length 0 encodes 256 bytes; 256 x 01 sums to 00.
    applyStimulus(8'h00);
    for (int i = 0; i < 256; i++) begin
      expectWrite(8'(i), 8'h01);
      applyStimulus(8'h01);
    end
    applyStimulus(8'h00);
    waitCycles(8);
    checkStatus("len256", 1'b1, 1'b0, 8'h00);
    checkOutput("len256_last_addr", 32'(bus.addr_bus), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clk cycles per serial bit (12 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial input, 8N1, idle high.
REQ-005 SHALL have port wr_enable  output  1  RAM write strobe, one cycle per data byte.
REQ-006 SHALL have port addr_bus  output  8  RAM write address.
REQ-007 SHALL have port wdata  output  8  RAM write data.
REQ-008 SHALL have port cpu_run  output  1  high = program loaded and verified, CPU released.
REQ-009 SHALL have port err  output  1  sticky error flag.
REQ-010 SHALL have port byte_count  output  8  data bytes written in current frame (LED display).
REQ-011 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-012 SHALL pass rx through a 2-flop synchroniser before any use; sampling latency 2 cycles.
REQ-013 Receiver SHALL detect start on synchronised high->low transition while idle.
REQ-014 Receiver SHALL re-sample at CLKS_PER_BIT/2 (integer division) cycles after the edge; if high, false start, return to idle, no byte.
REQ-015 Receiver SHALL then sample 8 data bits LSB first and one stop bit, each CLKS_PER_BIT cycles after the previous sample.
REQ-016 Stop bit low SHALL be a framing error: byte discarded, err set, loader to WAIT_LEN.
REQ-017 Valid byte SHALL produce internal byte_valid pulse of one cycle, in the cycle after the stop-bit sample.
REQ-018 Loader states: WAIT_LEN, WAIT_DATA, WAIT_SUM, RUNNING.
REQ-019 WAIT_LEN + byte_valid: latch length N (0x00 means 256), clear sum, byte_count=0, index=0, clear err, go WAIT_DATA.
REQ-020 WAIT_DATA + byte_valid: in the next cycle, wr_enable=1, addr_bus=index, wdata=byte; sum += byte mod 256; index and byte_count +1 (8-bit wrap).
REQ-021 After the Nth data byte, SHALL go WAIT_SUM; with N=256, byte_count wraps to 0x00 and index 0xFF is the last address written.
REQ-022 wr_enable SHALL be high exactly one cycle per data byte; addr_bus and wdata SHALL hold their last values otherwise.
REQ-023 WAIT_SUM + byte_valid: if byte equals sum, set cpu_run and go RUNNING; else set err and go WAIT_LEN.
REQ-024 RUNNING SHALL ignore all rx activity; cpu_run stays high until rst.
REQ-025 No wr_enable SHALL ever be issued in WAIT_LEN, WAIT_SUM or RUNNING.
REQ-026 rx low held through the stop sample (break) SHALL count as a framing error; receiver SHALL not restart until rx returns high.
REQ-027 No timeout: loader SHALL wait indefinitely in any WAIT_* state.

Reset
REQ-028 rst SHALL force: wr_enable=0, addr_bus=0x00, wdata=0x00, cpu_run=0, err=0, byte_count=0x00, state WAIT_LEN, receiver idle, synchroniser flops=1.
REQ-029 rst asserted mid-byte or mid-frame SHALL abandon the partial byte/frame; already written RAM contents are not the block's concern.
REQ-030 rst asserted in the same cycle as a pending write SHALL suppress the wr_enable pulse.

Verification (CLKS_PER_BIT=4)
REQ-031 Frame 03,11,22,33,66 -> writes (00,11),(01,22),(02,33), one-cycle strobes each, then cpu_run=1, err=0, byte_count=03.
REQ-032 Frame 02,AA,55,00 (wrong sum, expect FF) -> two writes, err=1, cpu_run=0; then frame 01,07,07 -> err clears on length byte, cpu_run=1.
REQ-033 Length 00 with 256 bytes of value 01 then sum 00 -> 256 writes addr 00..FF, byte_count=00, cpu_run=1.
REQ-034 rx low pulse of 1 cycle while idle -> no byte_valid, no write, state unchanged.
REQ-035 Byte with stop bit 0 during WAIT_DATA -> no write for that byte, err=1, state WAIT_LEN.
REQ-036 rst asserted after 2 of 3 data bytes -> all outputs at reset values next cycle; fresh frame then loads normally.
